// File: rtl/pipeline_exm_stage7_if.sv
// EXA->MEM bundle for the M-extension stage: EXA-side inputs, MEM-side registered outputs,
// the downstream stall and the upstream hold request.
interface pipeline_exm_stage7_if;
   logic        stall;
   logic        m_sel_EXA;
   logic [3:0]  alu_ctrl_EXA;
   logic [63:0] reg_data1_EXA;
   logic [63:0] reg_data2_EXA;
   logic [63:0] alu_result_EXA;
   logic [63:0] pc_EXA;
   logic [4:0]  rd_EXA;
   logic        rf_wr_en_EXA;
   logic [1:0]  rf_wr_sel_EXA;
   logic [2:0]  dm_rd_ctrl_EXA;
   logic [2:0]  dm_wr_ctrl_EXA;

   logic        stall_req;
   logic [63:0] result_MEM;
   logic [63:0] pc_MEM;
   logic [4:0]  rd_MEM;
   logic        rf_wr_en_MEM;
   logic [1:0]  rf_wr_sel_MEM;
   logic [2:0]  dm_rd_ctrl_MEM;
   logic [2:0]  dm_wr_ctrl_MEM;
   logic [63:0] reg_data2_MEM;

   modport master (
      output stall, m_sel_EXA, alu_ctrl_EXA, reg_data1_EXA, reg_data2_EXA, alu_result_EXA,
             pc_EXA, rd_EXA, rf_wr_en_EXA, rf_wr_sel_EXA, dm_rd_ctrl_EXA, dm_wr_ctrl_EXA,
      input  stall_req, result_MEM, pc_MEM, rd_MEM, rf_wr_en_MEM, rf_wr_sel_MEM,
             dm_rd_ctrl_MEM, dm_wr_ctrl_MEM, reg_data2_MEM
   );

   modport slave (
      input  stall, m_sel_EXA, alu_ctrl_EXA, reg_data1_EXA, reg_data2_EXA, alu_result_EXA,
             pc_EXA, rd_EXA, rf_wr_en_EXA, rf_wr_sel_EXA, dm_rd_ctrl_EXA, dm_wr_ctrl_EXA,
      output stall_req, result_MEM, pc_MEM, rd_MEM, rf_wr_en_MEM, rf_wr_sel_MEM,
             dm_rd_ctrl_MEM, dm_wr_ctrl_MEM, reg_data2_MEM
   );
endinterface

// File: rtl/pipeline_exm_stage7.sv
// EXA->MEM pipeline register with an embedded RV64M unit. ALU results pass in one cycle;
// multiply/divide ops hold the front of the pipe via stall_req and send bubbles to MEM.
module pipeline_exm_stage7 #(
   parameter int MUL_CYCLES = 2
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_exm_stage7_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);

   state_t      state, state_next;
   logic [7:0]  cnt;

   logic [63:0] op_a, op_b;
   logic [2:0]  op_f3;
   logic        op_w;
   logic [63:0] lat_pc;
   logic [4:0]  lat_rd;
   logic        lat_wr_en;
   logic [1:0]  lat_wr_sel;
   logic [2:0]  lat_dm_rd, lat_dm_wr;

   logic [127:0] prod;
   logic [63:0]  div_rem, div_q, div_res;

   logic stall_req_c, accept, load_alu, load_bubble, load_m;

   logic         a_signed, b_signed, a_neg, b_neg;
   logic [63:0]  a_ext, b_ext, a_mag, b_mag;
   logic [127:0] a_wide, b_wide, prod_full;
   logic [63:0]  q_init, rem_in, q_in, diff, rem_nxt, q_nxt, q_fix, r_fix;
   logic [64:0]  trial;
   logic         fits, is_rem, b_zero, ovf, div_special, div_last, div_store;
   logic [63:0]  div_raw, div_final, mul_raw, mul_final, m_result;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Operand shaping, the multiplier and one restoring-divide step, all from the latched op.
   always_comb begin
      a_signed  = (op_f3 == 3'd1) || (op_f3 == 3'd2) || (op_f3 == 3'd4) || (op_f3 == 3'd6);
      b_signed  = (op_f3 == 3'd1) || (op_f3 == 3'd4) || (op_f3 == 3'd6);
      a_ext     = op_w ? (a_signed ? sext32(op_a[31:0]) : {32'b0, op_a[31:0]}) : op_a;
      b_ext     = op_w ? (b_signed ? sext32(op_b[31:0]) : {32'b0, op_b[31:0]}) : op_b;
      a_neg     = a_signed & a_ext[63];
      b_neg     = b_signed & b_ext[63];
      a_mag     = a_neg ? (64'd0 - a_ext) : a_ext;
      b_mag     = b_neg ? (64'd0 - b_ext) : b_ext;

      a_wide    = {{64{a_neg}}, a_ext};
      b_wide    = {{64{b_neg}}, b_ext};
      prod_full = a_wide * b_wide;
      mul_raw   = (op_f3 == 3'd0) ? prod[63:0] : prod[127:64];
      mul_final = op_w ? sext32(mul_raw[31:0]) : mul_raw;

      q_init    = op_w ? {a_mag[31:0], 32'b0} : a_mag;
      rem_in    = (cnt == 8'd0) ? 64'd0 : div_rem;
      q_in      = (cnt == 8'd0) ? q_init : div_q;
      trial     = {rem_in, q_in[63]};
      fits      = trial >= {1'b0, b_mag};
      diff      = trial[63:0] - b_mag;
      rem_nxt   = fits ? diff : trial[63:0];
      q_nxt     = {q_in[62:0], fits};
      q_fix     = (a_neg ^ b_neg) ? (64'd0 - q_nxt) : q_nxt;
      r_fix     = a_neg ? (64'd0 - rem_nxt) : rem_nxt;

      is_rem      = op_f3[1];
      b_zero      = (b_ext == 64'd0);
      ovf         = a_signed && b_signed && (b_ext == {64{1'b1}}) &&
                    (a_ext == (op_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      div_special = b_zero || ovf;
      div_last    = (cnt == (op_w ? 8'd31 : 8'd63));
      div_store   = (state == DIV) && (((cnt == 8'd0) && div_special) || div_last);

      if (b_zero)
         div_raw = is_rem ? a_ext : {64{1'b1}};
      else if (ovf)
         div_raw = is_rem ? 64'd0 : a_ext;
      else
         div_raw = is_rem ? r_fix : q_fix;
      div_final = op_w ? sext32(div_raw[31:0]) : div_raw;

      m_result  = op_f3[2] ? div_res : mul_final;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic: accept in IDLE, count MUL/DIV cycles, leave DONE once MEM can take it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (!bus.stall && bus.m_sel_EXA)
                  state_next = bus.alu_ctrl_EXA[2] ? DIV : MUL;
         MUL:  if (cnt == MUL_LAST) state_next = DONE;
         DIV:  if (((cnt == 8'd0) && div_special) || div_last) state_next = DONE;
         DONE: if (!bus.stall) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: upstream hold request and output-register load strobes.
   always_comb begin
      stall_req_c = 1'b0;
      accept      = 1'b0;
      load_alu    = 1'b0;
      load_bubble = 1'b0;
      load_m      = 1'b0;
      case (state)
         IDLE: begin
            stall_req_c = bus.m_sel_EXA;
            if (!bus.stall) begin
               if (bus.m_sel_EXA) begin
                  accept      = 1'b1;
                  load_bubble = 1'b1;
               end else begin
                  load_alu = 1'b1;
               end
            end
         end
         MUL, DIV: stall_req_c = 1'b1;
         DONE:     load_m = !bus.stall;
         default:  stall_req_c = 1'b0;
      endcase
   end

   assign bus.stall_req = reset & stall_req_c;

   // Cycle counter for the MUL delay and DIV iterations; restarts on every state change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= 8'd0;
      else if (((state == MUL) || (state == DIV)) && (state_next == state))
         cnt <= cnt + 8'd1;
      else
         cnt <= 8'd0;
   end

   // Latch the M op and its write-back bundle when it is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_a <= '0; op_b <= '0; op_f3 <= '0; op_w <= 1'b0;
         lat_pc <= '0; lat_rd <= '0; lat_wr_en <= 1'b0; lat_wr_sel <= '0;
         lat_dm_rd <= '0; lat_dm_wr <= '0;
      end else if (accept) begin
         op_a       <= bus.reg_data1_EXA;
         op_b       <= bus.reg_data2_EXA;
         op_f3      <= bus.alu_ctrl_EXA[2:0];
         op_w       <= bus.alu_ctrl_EXA[3];
         lat_pc     <= bus.pc_EXA;
         lat_rd     <= bus.rd_EXA;
         lat_wr_en  <= bus.rf_wr_en_EXA;
         lat_wr_sel <= bus.rf_wr_sel_EXA;
         lat_dm_rd  <= bus.dm_rd_ctrl_EXA;
         lat_dm_wr  <= bus.dm_wr_ctrl_EXA;
      end
   end

   // Product is captured once on the first MUL cycle; the remaining cycles only delay it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          prod <= '0;
      else if ((state == MUL) && (cnt == 8'd0)) prod <= prod_full;
   end

   // Divider step registers and the sign-corrected (or special-case) result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_rem <= '0;
         div_q   <= '0;
         div_res <= '0;
      end else if (state == DIV) begin
         div_rem <= rem_nxt;
         div_q   <= q_nxt;
         if (div_store) div_res <= div_final;
      end
   end

   // MEM-side output register: ALU pass-through, bubble on acceptance, M result from DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.result_MEM     <= '0;
         bus.pc_MEM         <= '0;
         bus.rd_MEM         <= '0;
         bus.rf_wr_en_MEM   <= 1'b0;
         bus.rf_wr_sel_MEM  <= '0;
         bus.dm_rd_ctrl_MEM <= '0;
         bus.dm_wr_ctrl_MEM <= '0;
         bus.reg_data2_MEM  <= '0;
      end else if (load_alu) begin
         bus.result_MEM     <= bus.alu_result_EXA;
         bus.pc_MEM         <= bus.pc_EXA;
         bus.rd_MEM         <= bus.rd_EXA;
         bus.rf_wr_en_MEM   <= bus.rf_wr_en_EXA;
         bus.rf_wr_sel_MEM  <= bus.rf_wr_sel_EXA;
         bus.dm_rd_ctrl_MEM <= bus.dm_rd_ctrl_EXA;
         bus.dm_wr_ctrl_MEM <= bus.dm_wr_ctrl_EXA;
         bus.reg_data2_MEM  <= bus.reg_data2_EXA;
      end else if (load_bubble) begin
         bus.rf_wr_en_MEM   <= 1'b0;
         bus.dm_rd_ctrl_MEM <= '0;
         bus.dm_wr_ctrl_MEM <= '0;
      end else if (load_m) begin
         bus.result_MEM     <= m_result;
         bus.pc_MEM         <= lat_pc;
         bus.rd_MEM         <= lat_rd;
         bus.rf_wr_en_MEM   <= lat_wr_en;
         bus.rf_wr_sel_MEM  <= lat_wr_sel;
         bus.dm_rd_ctrl_MEM <= lat_dm_rd;
         bus.dm_wr_ctrl_MEM <= lat_dm_wr;
         bus.reg_data2_MEM  <= op_b;
      end
   end

endmodule

// File: tb/tb_pipeline_exm_stage7.sv
// Directed testbench for pipeline_exm_stage7: ALU pass-through, RV64M results, special
// divides, downstream stall in DONE and asynchronous reset mid-divide.
module tb_pipeline_exm_stage7;

   localparam int MC = 2;
   localparam logic [63:0] NOP_RESULT = 64'h0000_0000_0000_A5A5;
   localparam logic [63:0] NOP_PC     = 64'h0000_0000_0000_0100;
   localparam logic [63:0] OP_PC      = 64'h0000_0000_0000_2000;
   localparam logic [63:0] ALL1       = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV       = 64'h8000_0000_0000_0000;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   pipeline_exm_stage7_if bus ();

   pipeline_exm_stage7 #(.MUL_CYCLES(MC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic m_sel, input logic [3:0] ctrl, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] alu, input logic [63:0] pc,
                                input logic [4:0] rd, input logic wr_en, input logic [1:0] wr_sel,
                                input logic [2:0] dm_rd, input logic [2:0] dm_wr);
      bus.m_sel_EXA      = m_sel;
      bus.alu_ctrl_EXA   = ctrl;
      bus.reg_data1_EXA  = a;
      bus.reg_data2_EXA  = b;
      bus.alu_result_EXA = alu;
      bus.pc_EXA         = pc;
      bus.rd_EXA         = rd;
      bus.rf_wr_en_EXA   = wr_en;
      bus.rf_wr_sel_EXA  = wr_sel;
      bus.dm_rd_ctrl_EXA = dm_rd;
      bus.dm_wr_ctrl_EXA = dm_wr;
   endtask

   task automatic applyNop();
      applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, NOP_RESULT, NOP_PC, 5'd0, 1'b0, 2'd0, 3'd0, 3'd0);
   endtask

   // Issue one M op, play upstream (advance when stall_req drops) and check the result bundle.
   // exp_lat < 0 skips the latency comparison.
   task automatic doMOp(input string tag, input logic [3:0] ctrl, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input int exp_stall, input int exp_lat);
      int  edges;
      int  stall_cnt;
      int  wr_cnt;
      bit  done;
      edges = 0; stall_cnt = 0; wr_cnt = 0; done = 1'b0;
      applyStimulus(1'b1, ctrl, a, b, 64'h0BAD, OP_PC, 5'd10, 1'b1, 2'd1, 3'd0, 3'd0);
      #1;
      while (!done && edges < 200) begin
         if (bus.stall_req) stall_cnt++;
         else if (edges > 0) done = 1'b1;
         @(posedge clk); #1;
         edges++;
         if (bus.rf_wr_en_MEM) wr_cnt++;
         if (done) applyNop();
      end
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_result"}, bus.result_MEM, exp_res);
      checkOutput({tag, "_rd"}, 64'(bus.rd_MEM), 64'd10);
      checkOutput({tag, "_pc"}, bus.pc_MEM, OP_PC);
      checkOutput({tag, "_stallcyc"}, 64'(stall_cnt), 64'(exp_stall));
      if (exp_lat >= 0) checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_lat));
      @(posedge clk); #1;
      if (bus.rf_wr_en_MEM) wr_cnt++;
      checkOutput({tag, "_wr_once"}, 64'(wr_cnt), 64'd1);
      checkOutput({tag, "_next_nop"}, bus.result_MEM, NOP_RESULT);
   endtask

   initial begin
      int n;
      checks = 0;
      failures = 0;
      reset = 1'b0;
      bus.stall = 1'b0;
      applyStimulus(1'b1, 4'd0, 64'd1, 64'd2, 64'h77, 64'h40, 5'd3, 1'b1, 2'd1, 3'd1, 3'd1);

      // Reset state: outputs zero and stall_req gated low even with an M op presented
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_result", bus.result_MEM, 64'd0);
      checkOutput("rst_stall_req", 64'(bus.stall_req), 64'd0);
      checkOutput("rst_wr_en", 64'(bus.rf_wr_en_MEM), 64'd0);
      applyNop();
      reset = 1'b1;

      // ALU pass-through
      applyStimulus(1'b0, 4'd0, 64'd0, 64'hBEEF, 64'h1234, 64'h40, 5'd5, 1'b1, 2'd2, 3'd0, 3'd3);
      #1;
      checkOutput("alu_stall_req_pre", 64'(bus.stall_req), 64'd0);
      @(posedge clk); #1;
      checkOutput("alu_result", bus.result_MEM, 64'h1234);
      checkOutput("alu_rd", 64'(bus.rd_MEM), 64'd5);
      checkOutput("alu_store_data", bus.reg_data2_MEM, 64'hBEEF);
      checkOutput("alu_dm_wr", 64'(bus.dm_wr_ctrl_MEM), 64'd3);
      checkOutput("alu_wr_sel", 64'(bus.rf_wr_sel_MEM), 64'd2);
      checkOutput("alu_stall_req", 64'(bus.stall_req), 64'd0);

      // Downstream stall freezes the output register
      bus.stall = 1'b1;
      applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 64'h9999, 64'h44, 5'd7, 1'b1, 2'd0, 3'd0, 3'd0);
      @(posedge clk); #1;
      checkOutput("stall_hold_result", bus.result_MEM, 64'h1234);
      checkOutput("stall_hold_rd", 64'(bus.rd_MEM), 64'd5);
      bus.stall = 1'b0;
      applyNop();
      @(posedge clk); #1;

      // Multiplies
      doMOp("mul", 4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, MC + 1, MC + 2);
      doMOp("mulh", 4'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, ALL1, MC + 1, MC + 2);
      doMOp("mulhsu", 4'd2, ALL1, 64'd2, ALL1, MC + 1, MC + 2);
      doMOp("mulhu_small", 4'd3, ALL1, 64'd2, 64'd1, MC + 1, MC + 2);
      doMOp("mulw", 4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MC + 1, MC + 2);

      // Divides
      doMOp("div", 4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 66);
      doMOp("rem", 4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 65, 66);
      doMOp("div_negb", 4'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 66);
      doMOp("divu", 4'd5, 64'd100, 64'd7, 64'd14, 65, 66);
      doMOp("remu", 4'd7, 64'd100, 64'd7, 64'd2, 65, 66);
      doMOp("divw", 4'd12, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 34);

      // Divide special cases
      doMOp("div_by0", 4'd4, 64'd5, 64'd0, ALL1, 2, -1);
      doMOp("rem_by0", 4'd6, 64'd9, 64'd0, 64'd9, 2, -1);
      doMOp("div_ovf", 4'd4, MINV, ALL1, MINV, 2, -1);
      doMOp("rem_ovf", 4'd6, MINV, ALL1, 64'd0, 2, -1);

      // Downstream stall while in DONE: held 3 cycles, result lands after stall drops
      applyStimulus(1'b1, 4'd0, 64'd6, 64'd7, 64'h0BAD, OP_PC, 5'd10, 1'b1, 2'd1, 3'd0, 3'd0);
      #1;
      n = 0;
      while (bus.stall_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("done_reached", 64'(n), 64'(MC + 1));
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("done_hold_stall_req", 64'(bus.stall_req), 64'd0);
         checkOutput("done_hold_result", bus.result_MEM, NOP_RESULT);
         checkOutput("done_hold_wr_en", 64'(bus.rf_wr_en_MEM), 64'd0);
      end
      bus.stall = 1'b0;
      @(posedge clk); #1;
      checkOutput("done_release_result", bus.result_MEM, 64'd42);
      checkOutput("done_release_wr_en", 64'(bus.rf_wr_en_MEM), 64'd1);
      applyNop();
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a divide (iteration 20)
      applyStimulus(1'b1, 4'd4, 64'h0123_4567_89AB_CDEF, 64'd3, 64'h0BAD, OP_PC, 5'd10, 1'b1, 2'd1, 3'd0, 3'd0);
      repeat (21) @(posedge clk);
      #1;
      checkOutput("middiv_stall_req", 64'(bus.stall_req), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("arst_result", bus.result_MEM, 64'd0);
      checkOutput("arst_pc", bus.pc_MEM, 64'd0);
      checkOutput("arst_stall_req", 64'(bus.stall_req), 64'd0);
      #1;
      reset = 1'b1;
      doMOp("mulhu_after_rst", 4'd3, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, MC + 1, MC + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
